// File: rtl/laser_multi.sv
// ---------------------------------------------------------------------------
// laser_multi
//
// Multi-circle laser coverage engine. A job serially loads N_PTS target
// points on a 2^CW x 2^CW grid, then places N_CIRC circles of radius RADIUS
// on grid positions using alternating greedy sweeps (one full-grid sweep per
// circle per pass, at most MAX_ITER passes) to maximise the number of covered
// points. Results are reported with a one-cycle DONE pulse.
//
// Optional feature macro: LASER_EARLY_EXIT_EN
//   defined   : a pass that changed no centre ends the job early.
//   undefined : exactly MAX_ITER passes are always run.
//   Final centres and cover count are identical either way.
//
// Ports:
//   CLK       in   clock
//   RST_N     in   asynchronous active-low reset
//   IN_VALID  in   point valid
//   IN_READY  out  engine is loading points
//   X, Y      in   [CW-1:0] point coordinates
//   CX, CY    out  [N_CIRC*CW-1:0] packed centres, circle k at [k*CW +: CW]
//   COVER     out  [clog2(N_PTS+1)-1:0] points covered by reported centres
//   DONE      out  one-cycle result pulse
// ---------------------------------------------------------------------------
module laser_multi #(
    parameter int N_PTS    = 40,
    parameter int CW       = 4,
    parameter int RADIUS   = 4,
    parameter int N_CIRC   = 2,
    parameter int MAX_ITER = 4
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [CW-1:0]                X,
    input  logic [CW-1:0]                Y,
    output logic [N_CIRC*CW-1:0]         CX,
    output logic [N_CIRC*CW-1:0]         CY,
    output logic [$clog2(N_PTS+1)-1:0]   COVER,
    output logic                         DONE
);

    localparam int G   = 1 << (2 * CW);
    localparam int IW  = 2 * CW;
    localparam int PCW = $clog2(N_PTS + 1);
    localparam int NW  = (N_PTS > 1) ? $clog2(N_PTS) : 1;
    localparam int KW  = (N_CIRC > 1) ? $clog2(N_CIRC) : 1;
    localparam int PW  = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;
    localparam int DW  = 2 * CW + 3;

    localparam logic signed [DW-1:0] R2 = DW'(RADIUS * RADIUS);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SCAN   = 2'd1,
        S_UPDATE = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    // Euclidean containment test. Differences are taken as signed CW+1 bit
    // values so the grid edges never wrap: (0,y) to (2^CW-1,y) is a long way.
    function automatic logic in_circle(input logic [CW-1:0] px,
                                       input logic [CW-1:0] py,
                                       input logic [CW-1:0] qx,
                                       input logic [CW-1:0] qy);
        logic signed [CW:0]     dx;
        logic signed [CW:0]     dy;
        logic signed [2*CW+1:0] dx_w;
        logic signed [2*CW+1:0] dy_w;
        logic signed [2*CW+1:0] dx2;
        logic signed [2*CW+1:0] dy2;
        logic signed [DW-1:0]   d2;
        dx   = $signed({1'b0, px}) - $signed({1'b0, qx});
        dy   = $signed({1'b0, py}) - $signed({1'b0, qy});
        dx_w = {{(CW+1){dx[CW]}}, dx};
        dy_w = {{(CW+1){dy[CW]}}, dy};
        dx2  = dx_w * dx_w;
        dy2  = dy_w * dy_w;
        d2   = {dx2[2*CW+1], dx2} + {dy2[2*CW+1], dy2};
        return (d2 <= R2);
    endfunction

    state_t                state_q, state_d;
    logic [NW-1:0]         ld_cnt_q, ld_cnt_d;
    logic [CW-1:0]         pt_x_q [N_PTS];
    logic [CW-1:0]         pt_x_d [N_PTS];
    logic [CW-1:0]         pt_y_q [N_PTS];
    logic [CW-1:0]         pt_y_d [N_PTS];
    logic [CW-1:0]         cen_x_q [N_CIRC];
    logic [CW-1:0]         cen_x_d [N_CIRC];
    logic [CW-1:0]         cen_y_q [N_CIRC];
    logic [CW-1:0]         cen_y_d [N_CIRC];
    logic [KW-1:0]         k_q, k_d;
    logic [PW-1:0]         pass_q, pass_d;
    logic                  chg_q, chg_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         best_q, best_d;
    logic [PCW-1:0]        best_tot_q, best_tot_d;
    logic [PCW-1:0]        cur_tot_q, cur_tot_d;
    logic [PCW-1:0]        cover_q, cover_d;
    logic [N_CIRC*CW-1:0]  cx_q, cx_d;
    logic [N_CIRC*CW-1:0]  cy_q, cy_d;

    logic [CW-1:0]         cand_x, cand_y;
    logic [N_PTS-1:0]      hit;
    logic [PCW-1:0]        total;
    logic                  at_cur;
    logic                  improve;
    logic                  fin;

    assign cand_x = idx_q[CW-1:0];
    assign cand_y = idx_q[IW-1:CW];

    // Coverage of the whole circle set with circle k moved to the current
    // candidate: a point counts if the candidate or any other circle hits it.
    always_comb begin
        hit   = '0;
        total = '0;
        for (int p = 0; p < N_PTS; p++) begin
            hit[p] = in_circle(pt_x_q[p], pt_y_q[p], cand_x, cand_y);
            for (int j = 0; j < N_CIRC; j++) begin
                if (KW'(j) != k_q) begin
                    hit[p] = hit[p] | in_circle(pt_x_q[p], pt_y_q[p],
                                                cen_x_q[j], cen_y_q[j]);
                end
            end
            total = total + PCW'(hit[p]);
        end
    end

    // The sweep visits every grid position, including the present C_k, so
    // the "keep C_k as is" total is captured in passing rather than computed
    // by a separate evaluator.
    assign at_cur  = (cand_x == cen_x_q[k_q]) && (cand_y == cen_y_q[k_q]);
    assign improve = (best_tot_q > cur_tot_q);

    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        pt_x_d     = pt_x_q;
        pt_y_d     = pt_y_q;
        cen_x_d    = cen_x_q;
        cen_y_d    = cen_y_q;
        k_d        = k_q;
        pass_d     = pass_q;
        chg_d      = chg_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_tot_d = best_tot_q;
        cur_tot_d  = cur_tot_q;
        cover_d    = cover_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        fin        = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (IN_VALID) begin
                    pt_x_d[ld_cnt_q] = X;
                    pt_y_d[ld_cnt_q] = Y;
                    if (ld_cnt_q == NW'(N_PTS - 1)) begin
                        ld_cnt_d = '0;
                        for (int j = 0; j < N_CIRC; j++) begin
                            cen_x_d[j] = '0;
                            cen_y_d[j] = '0;
                        end
                        k_d     = '0;
                        pass_d  = '0;
                        chg_d   = 1'b0;
                        idx_d   = '0;
                        state_d = S_SCAN;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                    end
                end
            end

            S_SCAN: begin
                // Index 0 seeds the running best; afterwards strict '>' keeps
                // the lowest index among equal totals.
                if ((idx_q == '0) || (total > best_tot_q)) begin
                    best_d     = idx_q;
                    best_tot_d = total;
                end
                if (at_cur) begin
                    cur_tot_d = total;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(G - 1)) begin
                    state_d = S_UPDATE;
                end
            end

            S_UPDATE: begin
                if (improve) begin
                    cen_x_d[k_q] = best_q[CW-1:0];
                    cen_y_d[k_q] = best_q[IW-1:CW];
                    chg_d        = 1'b1;
                end
                // Coverage of the set as it stands after this decision.
                cover_d = improve ? best_tot_q : cur_tot_q;
                for (int j = 0; j < N_CIRC; j++) begin
                    cx_d[j*CW +: CW] = cen_x_d[j];
                    cy_d[j*CW +: CW] = cen_y_d[j];
                end
                // End-of-pass bookkeeping is folded into this cycle.
                if (k_q == KW'(N_CIRC - 1)) begin
                    k_d    = '0;
                    pass_d = pass_q + 1'b1;
                    fin    = (pass_q == PW'(MAX_ITER - 1));
`ifdef LASER_EARLY_EXIT_EN
                    fin    = fin || !chg_d;
`else
                    fin    = fin;
`endif
                    if (fin) begin
                        state_d = S_FIN;
                    end else begin
                        chg_d   = 1'b0;
                        state_d = S_SCAN;
                    end
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_SCAN;
                end
            end

            S_FIN: begin
                ld_cnt_d = '0;
                state_d  = S_LOAD;
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_LOAD;
            ld_cnt_q   <= '0;
            cen_x_q    <= '{default: '0};
            cen_y_q    <= '{default: '0};
            k_q        <= '0;
            pass_q     <= '0;
            chg_q      <= 1'b0;
            idx_q      <= '0;
            best_q     <= '0;
            best_tot_q <= '0;
            cur_tot_q  <= '0;
            cover_q    <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            cen_x_q    <= cen_x_d;
            cen_y_q    <= cen_y_d;
            k_q        <= k_d;
            pass_q     <= pass_d;
            chg_q      <= chg_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_tot_q <= best_tot_d;
            cur_tot_q  <= cur_tot_d;
            cover_q    <= cover_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
        end
    end

    // Point storage is pure data: a reset discards the job through the load
    // counter, so the stored values themselves need no reset.
    always_ff @(posedge CLK) begin
        pt_x_q <= pt_x_d;
        pt_y_q <= pt_y_d;
    end

    assign IN_READY = (state_q == S_LOAD);
    assign DONE     = (state_q == S_FIN);
    assign CX       = cx_q;
    assign CY       = cy_q;
    assign COVER    = cover_q;

endmodule
